// File: rtl/onehot_decoder_buf.sv
// Binary-to-one-hot decoder with a two-entry valid/ready buffer between producer and consumer.
// Every output is driven straight from a flop, so nothing combinational connects input to output.
module onehot_decoder_buf #(
    parameter int unsigned IN_W  = 3,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  code_in,
    input  logic             code_en,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] onehot_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_cnt
);

    // The state value is the buffer occupancy.
    localparam logic [1:0] FULL_OCC = 2'(DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = FULL_OCC
    } state_t;

    localparam logic [OUT_W-1:0] ZERO_WORD = {OUT_W{1'b0}};

    function automatic logic [OUT_W-1:0] decode(input logic [IN_W-1:0] code, input logic en);
        logic [OUT_W-1:0] word;
        if (en) begin
            word = {{(OUT_W-1){1'b0}}, 1'b1} << code;
        end else begin
            word = ZERO_WORD;
        end
        return word;
    endfunction

    state_t           state_q, state_d;
    logic [OUT_W-1:0] head_q, head_d;
    logic [OUT_W-1:0] tail_q, tail_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    logic             push_s;
    logic             pop_s;
    logic [OUT_W-1:0] new_word_s;

    assign push_s     = in_valid & in_ready_q;
    assign pop_s      = out_valid_q & out_ready;
    assign new_word_s = decode(code_in, code_en);

    // Next-state, buffer contents and handshake flags.
    // The head entry is zeroed whenever the buffer empties, so onehot_out reads 0 when idle.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            S_EMPTY: begin
                if (push_s) begin
                    head_d  = new_word_s;
                    state_d = S_ONE;
                end else begin
                    state_d = S_EMPTY;
                end
            end
            S_ONE: begin
                if (push_s && pop_s) begin
                    head_d  = new_word_s;
                    state_d = S_ONE;
                end else if (push_s) begin
                    tail_d  = new_word_s;
                    state_d = S_FULL;
                end else if (pop_s) begin
                    head_d  = ZERO_WORD;
                    state_d = S_EMPTY;
                end else begin
                    state_d = S_ONE;
                end
            end
            S_FULL: begin
                if (pop_s) begin
                    head_d  = tail_q;
                    tail_d  = ZERO_WORD;
                    state_d = S_ONE;
                end else begin
                    state_d = S_FULL;
                end
            end
            default: begin
                head_d  = ZERO_WORD;
                tail_d  = ZERO_WORD;
                state_d = S_EMPTY;
            end
        endcase

        in_ready_d  = (state_d != S_FULL);
        out_valid_d = (state_d != S_EMPTY);

        if (pop_s) begin
            word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            word_cnt_d = word_cnt_q;
        end
    end

    // State, storage and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            head_q      <= ZERO_WORD;
            tail_q      <= ZERO_WORD;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            word_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign onehot_out = head_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_onehot_decoder_buf.sv
// Directed bench for onehot_decoder_buf: reset, decode, stall, simultaneous push/pop, sweep, wrap.
module tb_onehot_decoder_buf;

    logic       clk;
    logic       rst_n;
    logic [2:0] code_in;
    logic       code_en;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] onehot_out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] word_cnt;

    int checks;
    int errors;

    onehot_decoder_buf #(.IN_W(3), .OUT_W(8), .DEPTH(2), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .code_en    (code_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .onehot_out (onehot_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_cnt   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; code_in = 3'd0; code_en = 1'b1;
        step(); step();
        checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (onehot_out !== 8'h00)  begin errors++; $display("FAIL reset_onehot: got %h expected 00", onehot_out); end
        checks++; if (word_cnt !== 8'd0)     begin errors++; $display("FAIL reset_cnt: got %0d expected 0", word_cnt); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1; code_in = 3'd3; code_en = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (onehot_out !== 8'h08)  begin errors++; $display("FAIL single_onehot: got %h expected 08", onehot_out); end
        checks++; if (out_valid !== 1'b1)    begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        step();
        checks++; if (word_cnt !== 8'd1)     begin errors++; $display("FAIL single_cnt: got %0d expected 1", word_cnt); end
        checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL single_drain_valid: got %b expected 0", out_valid); end
        checks++; if (onehot_out !== 8'h00)  begin errors++; $display("FAIL single_empty_onehot: got %h expected 00", onehot_out); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0; in_valid = 1'b1; code_en = 1'b1; code_in = 3'd5;
        step();
        code_in = 3'd6;
        step();
        checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL stall_full_ready: got %b expected 0", in_ready); end
        checks++; if (onehot_out !== 8'h20)  begin errors++; $display("FAIL stall_head: got %h expected 20", onehot_out); end
        code_in = 3'd7;
        step();
        checks++; if (onehot_out !== 8'h20)  begin errors++; $display("FAIL stall_hold: got %h expected 20", onehot_out); end
        checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL stall_hold_ready: got %b expected 0", in_ready); end
        out_ready = 1'b1;
        step();
        checks++; if (onehot_out !== 8'h40)  begin errors++; $display("FAIL stall_second: got %h expected 40", onehot_out); end
        checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL stall_reopen: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (onehot_out !== 8'h80)  begin errors++; $display("FAIL stall_word7: got %h expected 80", onehot_out); end
        checks++; if (word_cnt !== 8'd3)     begin errors++; $display("FAIL stall_cnt_mid: got %0d expected 3", word_cnt); end
        step();
        checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL stall_empty: got %b expected 0", out_valid); end
        checks++; if (word_cnt !== 8'd4)     begin errors++; $display("FAIL stall_cnt: got %0d expected 4", word_cnt); end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0; in_valid = 1'b1; code_en = 1'b1; code_in = 3'd0;
        step();
        checks++; if (onehot_out !== 8'h01)  begin errors++; $display("FAIL simul_head: got %h expected 01", onehot_out); end
        code_in = 3'd2; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (onehot_out !== 8'h04)  begin errors++; $display("FAIL simul_new_head: got %h expected 04", onehot_out); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1)
            begin errors++; $display("FAIL simul_state_one: got ready=%b valid=%b expected ready=1 valid=1", in_ready, out_valid); end
        checks++; if (word_cnt !== 8'd5)     begin errors++; $display("FAIL simul_cnt: got %0d expected 5", word_cnt); end
        step();
        checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL simul_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_sweep();
        logic [7:0] exp;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            code_in = 3'(k % 8);
            code_en = (k < 8) ? 1'b1 : 1'b0;
            step();
            exp = (k < 8) ? (8'h01 << k) : 8'h00;
            checks++; if (onehot_out !== exp) begin errors++; $display("FAIL sweep_%0d: got %h expected %h", k, onehot_out, exp); end
            checks++; if ($countones(onehot_out) > 1 || out_valid !== 1'b1)
                begin errors++; $display("FAIL sweep_onehot_%0d: got %h valid=%b expected at most one bit, valid=1", k, onehot_out, out_valid); end
        end
        in_valid = 1'b0; code_en = 1'b1;
        step();
        checks++; if (word_cnt !== 8'd15)    begin errors++; $display("FAIL sweep_cnt: got %0d expected 15", word_cnt); end
    endtask

    task automatic test_wrap_reset();
        out_ready = 1'b1; in_valid = 1'b1; code_en = 1'b1;
        for (int i = 0; i < 241; i++) begin
            code_in = 3'(i % 8);
            step();
        end
        checks++; if (word_cnt !== 8'd255)   begin errors++; $display("FAIL wrap_255: got %0d expected 255", word_cnt); end
        in_valid = 1'b0;
        step();
        checks++; if (word_cnt !== 8'd0)     begin errors++; $display("FAIL wrap_zero: got %0d expected 0", word_cnt); end
        out_ready = 1'b0; in_valid = 1'b1; code_in = 3'd1;
        step();
        code_in = 3'd4;
        step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || onehot_out !== 8'h02)
            begin errors++; $display("FAIL wrap_full: got ready=%b onehot=%h expected ready=0 onehot=02", in_ready, onehot_out); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || onehot_out !== 8'h00)
            begin errors++; $display("FAIL async_reset: got ready=%b valid=%b onehot=%h expected 1 0 00", in_ready, out_valid, onehot_out); end
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || word_cnt !== 8'd0)
            begin errors++; $display("FAIL reset_dropped: got valid=%b cnt=%0d expected valid=0 cnt=0", out_valid, word_cnt); end
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || word_cnt !== 8'd0)
            begin errors++; $display("FAIL idle_empty: got valid=%b ready=%b cnt=%0d expected 0 1 0", out_valid, in_ready, word_cnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_stall();
        test_simultaneous();
        test_sweep();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
